// File: rtl/group_divisor_scan_pkg.sv
// Shared definitions for the grouped divisor scanner: FSM state encoding
// and the scan-direction (Mode) encodings.
package group_divisor_scan_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_GRP_INIT  = 4'd1,
    S_RD_REQ    = 4'd2,
    S_RD_WAIT   = 4'd3,
    S_MOD_START = 4'd4,
    S_MOD_WAIT  = 4'd5,
    S_EVAL      = 4'd6,
    S_NEXT_CAND = 4'd7,
    S_EMIT      = 4'd8,
    S_NEXT_GRP  = 4'd9,
    S_FIN       = 4'd10
  } state_e;

  // Mode 0 walks candidates upward from 2, Mode 1 walks downward from all-ones.
  localparam logic MODE_SMALLEST = 1'b0;
  localparam logic MODE_LARGEST  = 1'b1;

endpackage

// File: rtl/group_divisor_scan_mod_unit.sv
// Restoring remainder unit: Rem = Dividend mod Divisor, one dividend bit per
// cycle. Busy is high for exactly D_WIDTH cycles after a Start pulse; Rem is
// valid once Busy falls. Divisor must be non-zero.
module mod_unit #(
  parameter int D_WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [D_WIDTH-1:0] Dividend,
  input  logic [D_WIDTH-1:0] Divisor,
  output logic               Busy,
  output logic [D_WIDTH-1:0] Rem
);

  localparam int C_W = $clog2(D_WIDTH + 1);

  logic [D_WIDTH-1:0] rem_q, rem_d;
  logic [D_WIDTH-1:0] shift_q, shift_d;
  logic [D_WIDTH-1:0] div_q, div_d;
  logic [C_W-1:0]     cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [D_WIDTH:0]   trial;

  // One restoring step per busy cycle; a Start while idle loads the operands.
  always_comb begin
    rem_d   = rem_q;
    shift_d = shift_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    trial   = {rem_q, shift_q[D_WIDTH-1]};
    if (busy_q) begin
      // Partial remainder is always below the divisor, so the difference fits.
      if (trial >= {1'b0, div_q}) rem_d = D_WIDTH'(trial - {1'b0, div_q});
      else                        rem_d = D_WIDTH'(trial);
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - C_W'(1);
      if (cnt_q == C_W'(1)) busy_d = 1'b0;
    end else if (Start) begin
      rem_d   = '0;
      shift_d = Dividend;
      div_d   = Divisor;
      cnt_d   = C_W'(D_WIDTH);
      busy_d  = 1'b1;
    end
  end

  // Operand and progress registers, cleared to idle by reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rem_q   <= '0;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign Rem  = rem_q;

endmodule

// File: rtl/group_divisor_scan.sv
// Grouped divisor scanner: for each group of GROUP_SIZE memory words, finds the
// smallest (Mode 0, from 2) or largest (Mode 1, from all-ones) candidate that
// divides at least HitThresh words, re-reading the group for every candidate.
// Result handshake: Result/ResultGrp are valid and held while ResultValid is
// high; the consumer accepts by raising ResultAck, sampled on a rising edge
// while ResultValid is high, and ResultValid drops on the following cycle.
// ResultAck is ignored whenever ResultValid is low.
module group_divisor_scan
  import group_divisor_scan_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int A_WIDTH    = 8,
  parameter int GROUP_SIZE = 4,
  parameter int NUM_GROUPS = 64
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            Go,
  input  logic                            Mode,
  input  logic [$clog2(GROUP_SIZE):0]     HitThresh,
  output logic [A_WIDTH-1:0]              Addr,
  output logic                            Rw,
  output logic                            En,
  input  logic [D_WIDTH-1:0]              Data,
  output logic [D_WIDTH-1:0]              Result,
  output logic [$clog2(NUM_GROUPS)-1:0]   ResultGrp,
  output logic                            ResultValid,
  input  logic                            ResultAck,
  output logic                            Busy,
  output logic                            Done,
  output logic [3:0]                      dbg_state
);

  localparam int J_W = $clog2(GROUP_SIZE);
  localparam int T_W = J_W + 1;
  localparam int G_W = $clog2(NUM_GROUPS);
  localparam int C_W = D_WIDTH + 1;  // one spare bit so candidate stepping never wraps

  localparam logic [J_W-1:0] LAST_J   = J_W'(GROUP_SIZE - 1);
  localparam logic [G_W-1:0] LAST_G   = G_W'(NUM_GROUPS - 1);
  localparam logic [T_W-1:0] GS_T     = T_W'(GROUP_SIZE);
  localparam logic [C_W-1:0] CAND_MAX = C_W'((1 << D_WIDTH) - 1);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [T_W-1:0]     thr_q, thr_d;
  logic [T_W-1:0]     hits_q, hits_d;
  logic [G_W-1:0]     g_q, g_d;
  logic [J_W-1:0]     j_q, j_d;
  logic [C_W-1:0]     cand_q, cand_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic [D_WIDTH-1:0] result_q, result_d;
  logic               done_q, done_d;
  logic               mod_start, mod_busy;
  logic [D_WIDTH-1:0] mod_rem;

  mod_unit #(.D_WIDTH(D_WIDTH)) u_mod (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (mod_start),
    .Dividend (data_q),
    .Divisor  (cand_q[D_WIDTH-1:0]),
    .Busy     (mod_busy),
    .Rem      (mod_rem)
  );

  // Next-state and datapath updates for the scan sequence.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    thr_d     = thr_q;
    hits_d    = hits_q;
    g_d       = g_q;
    j_d       = j_q;
    cand_d    = cand_q;
    data_d    = data_q;
    result_d  = result_q;
    done_d    = done_q;
    mod_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Go) begin
          mode_d  = Mode;
          thr_d   = (HitThresh == '0 || HitThresh > GS_T) ? GS_T : HitThresh;
          g_d     = '0;
          done_d  = 1'b0;
          state_d = S_GRP_INIT;
        end
      end
      S_GRP_INIT: begin
        cand_d  = (mode_q == MODE_SMALLEST) ? C_W'(2) : CAND_MAX;
        j_d     = '0;
        hits_d  = '0;
        state_d = S_RD_REQ;
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        data_d  = Data;
        state_d = S_MOD_START;
      end
      S_MOD_START: begin
        mod_start = 1'b1;
        state_d   = S_MOD_WAIT;
      end
      S_MOD_WAIT: begin
        // A zero word leaves a zero remainder, so it counts as a hit naturally.
        if (!mod_busy) begin
          if (mod_rem == '0) hits_d = hits_q + T_W'(1);
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (j_q != LAST_J) begin
          j_d     = j_q + J_W'(1);
          state_d = S_RD_REQ;
        end else if (hits_q >= thr_q) begin
          result_d = cand_q[D_WIDTH-1:0];
          state_d  = S_EMIT;
        end else begin
          state_d = S_NEXT_CAND;
        end
      end
      S_NEXT_CAND: begin
        j_d    = '0;
        hits_d = '0;
        if (mode_q == MODE_SMALLEST) begin
          if (cand_q >= CAND_MAX) begin
            result_d = '0;
            state_d  = S_EMIT;
          end else begin
            cand_d  = cand_q + C_W'(1);
            state_d = S_RD_REQ;
          end
        end else begin
          // Every word is divisible by 1, so reaching it ends the search.
          if (cand_q <= C_W'(2)) begin
            cand_d   = C_W'(1);
            result_d = D_WIDTH'(1);
            state_d  = S_EMIT;
          end else begin
            cand_d  = cand_q - C_W'(1);
            state_d = S_RD_REQ;
          end
        end
      end
      S_EMIT: begin
        if (ResultAck) state_d = S_NEXT_GRP;
      end
      S_NEXT_GRP: begin
        if (g_q != LAST_G) begin
          g_d     = g_q + G_W'(1);
          state_d = S_GRP_INIT;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_SMALLEST;
      thr_q    <= '0;
      hits_q   <= '0;
      g_q      <= '0;
      j_q      <= '0;
      cand_q   <= '0;
      data_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      thr_q    <= thr_d;
      hits_q   <= hits_d;
      g_q      <= g_d;
      j_q      <= j_d;
      cand_q   <= cand_d;
      data_q   <= data_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // GROUP_SIZE is a power of two, so g*GROUP_SIZE + j is a concatenation.
  assign Addr        = A_WIDTH'({g_q, j_q});
  assign Rw          = 1'b0;
  assign En          = (state_q == S_RD_REQ);
  assign Result      = result_q;
  assign ResultGrp   = g_q;
  assign ResultValid = (state_q == S_EMIT);
  assign Busy        = (state_q != S_IDLE) && (state_q != S_FIN);
  assign Done        = done_q || (state_q == S_FIN);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_group_divisor_scan.sv
// Bench for group_divisor_scan with D_WIDTH=8, GROUP_SIZE=4, NUM_GROUPS=2.
module tb_group_divisor_scan;
  import group_divisor_scan_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int GS = 4;
  localparam int NG = 2;
  localparam int TW = 3;
  localparam int GW = 1;
  localparam int BUDGET = 30000;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          go, mode, rw, en, result_valid, result_ack, busy, done;
  logic [TW-1:0] hit_thresh;
  logic [AW-1:0] addr;
  logic [DW-1:0] data, result;
  logic [GW-1:0] result_grp;
  logic [3:0]    dbg_state;

  logic [DW-1:0] mem [0:NG*GS-1];
  logic [15:0]   exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;

  group_divisor_scan #(.D_WIDTH(DW), .A_WIDTH(AW), .GROUP_SIZE(GS), .NUM_GROUPS(NG)) dut (
    .Clk(clk), .Rst(rst), .Go(go), .Mode(mode), .HitThresh(hit_thresh),
    .Addr(addr), .Rw(rw), .En(en), .Data(data),
    .Result(result), .ResultGrp(result_grp), .ResultValid(result_valid),
    .ResultAck(result_ack), .Busy(busy), .Done(done), .dbg_state(dbg_state)
  );

  // Memory model: read data appears the cycle after the strobe.
  always @(posedge clk) if (en) data <= mem[addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: plain search using the % operator over the bench memory image.
  function automatic logic [7:0] ref_div(input logic m, input int thr, input int grp);
    int t;
    int cnt;
    t = (thr == 0 || thr > GS) ? GS : thr;
    if (m == 1'b0) begin
      for (int v = 2; v <= 255; v++) begin
        cnt = 0;
        for (int j = 0; j < GS; j++) if ((int'(mem[grp*GS+j]) % v) == 0) cnt++;
        if (cnt >= t) return 8'(v);
      end
      return 8'd0;
    end
    for (int v = 255; v >= 2; v--) begin
      cnt = 0;
      for (int j = 0; j < GS; j++) if ((int'(mem[grp*GS+j]) % v) == 0) cnt++;
      if (cnt >= t) return 8'(v);
    end
    return 8'd1;
  endfunction

  task automatic load_mem(input logic [8*DW-1:0] img);
    for (int i = 0; i < NG*GS; i++) mem[i] = img[(NG*GS-1-i)*DW +: DW];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_en"}, en, 0);
    check({tag, "_rw"}, rw, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_grp"}, result_grp, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, dbg_state, 32'(S_IDLE));
  endtask

  // Driver: one full run; expected results are queued at Go and popped on ResultValid.
  task automatic run_scan(input logic m, input logic [TW-1:0] thr, input int ack_delay,
                          input bit ack_always, input bit go_busy);
    int cyc;
    int got_n;
    bit first_en;
    logic [15:0] e;
    for (int g = 0; g < NG; g++) exp_q.push_back({8'(g), ref_div(m, int'(thr), g)});
    @(negedge clk);
    mode = m; hit_thresh = thr; go = 1'b1; result_ack = ack_always;
    @(negedge clk);
    go = 1'b0; mode = ~m; hit_thresh = thr ^ 3'b101;
    check("busy_after_go", busy, 1);
    check("done_cleared", done, 0);
    cyc = 0; got_n = 0; first_en = 1'b1;
    while (got_n < NG && cyc < BUDGET) begin
      if (en && first_en) begin
        check("first_addr", addr, 0);
        check("rw_read", rw, 0);
        first_en = 1'b0;
      end
      if (result_valid) begin
        e = exp_q.pop_front();
        check("result", result, e[7:0]);
        check("result_grp", result_grp, e[15:8]);
        if (got_n == NG-1) check("done_before_last_ack", done, 0);
        for (int k = 0; k < ack_delay; k++) begin
          @(negedge clk);
          check("hold_result", result, e[7:0]);
          check("hold_valid", result_valid, 1);
          check("no_en_in_emit", en, 0);
        end
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = ack_always;
        got_n++;
        if (go_busy && got_n == 1) begin
          go = 1'b1; @(negedge clk); go = 1'b0;
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (got_n < NG) begin
      check("timeout_results", got_n, NG);
      exp_q.delete();
    end
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    check("done_at_end", done, 1);
    check("busy_at_end", busy, 0);
    check("exp_q_drained", exp_q.size(), 0);
    result_ack = 1'b0;
  endtask

  int cyc;
  int en_cnt;

  initial begin
    rst = 1'b1; go = 1'b0; mode = 1'b0; hit_thresh = '0; result_ack = 1'b0;
    load_mem({8'd12, 8'd18, 8'd24, 8'd30, 8'd7, 8'd11, 8'd13, 8'd17});
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_scan(1'b0, 3'd4, 0, 1'b0, 1'b1);  // 2, 0 with a stray Go mid-run
    run_scan(1'b1, 3'd4, 0, 1'b0, 1'b0);  // 6, 1
    run_scan(1'b0, 3'd1, 0, 1'b1, 1'b0);  // 2, 7 with ack held high throughout

    load_mem('0);
    run_scan(1'b0, 3'd4, 0, 1'b0, 1'b0);  // 2, 2
    run_scan(1'b1, 3'd4, 5, 1'b0, 1'b0);  // 255, 255 with delayed ack

    load_mem({8'd12, 8'd18, 8'd24, 8'd30, 8'd6, 8'd12, 8'd18, 8'd9});
    run_scan(1'b0, 3'd0, 1, 1'b0, 1'b0);  // threshold 0 acts as 4: 2, 3
    run_scan(1'b0, 3'd7, 0, 1'b0, 1'b0);  // threshold 7 acts as 4: 2, 3
    run_scan(1'b0, 3'd1, 0, 1'b0, 1'b0);  // 2, 2

    // Asynchronous reset while group 1 is dividing.
    @(negedge clk);
    mode = 1'b0; hit_thresh = 3'd4; go = 1'b1; result_ack = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cyc = 0;
    while (!(dbg_state == 4'(S_MOD_WAIT) && result_grp == 1'b1) && cyc < BUDGET) begin
      @(negedge clk); cyc++;
    end
    check("reached_g1_mod_wait", dbg_state, 32'(S_MOD_WAIT));
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    result_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en || result_valid) en_cnt++;
    end
    check("quiet_after_rst", en_cnt, 0);
    run_scan(1'b0, 3'd4, 2, 1'b0, 1'b0);  // restart from address 0: 2, 3

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/group_divisor_scan.md
GROUP_DIVISOR_SCAN -- requirements
Module: group_divisor_scan

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, data word and candidate width.
REQ-002 SHALL have parameter A_WIDTH, default 8, memory address width.
REQ-003 SHALL have parameter GROUP_SIZE, default 4, words per group (power of two, 2..16).
REQ-004 SHALL have parameter NUM_GROUPS, default 64, groups per run; NUM_GROUPS*GROUP_SIZE <= 2^A_WIDTH.
REQ-005 Clk  in  1  sole clock, rising edge.
REQ-006 Rst  in  1  reset, asynchronous, active-high.
REQ-007 Go  in  1  start request, sampled in IDLE only.
REQ-008 Mode  in  1  0 = smallest qualifying divisor >= 2, 1 = largest qualifying divisor; latched at Go.
REQ-009 HitThresh  in  clog2(GROUP_SIZE)+1  minimum dividing words per group; latched at Go; 0 or > GROUP_SIZE treated as GROUP_SIZE.
REQ-010 Addr  out  A_WIDTH  memory address = g*GROUP_SIZE + j.
REQ-011 Rw  out  1  always 0 (read only).
REQ-012 En  out  1  one-cycle memory read strobe.
REQ-013 Data  in  D_WIDTH  read data, valid the cycle after En.
REQ-014 Result  out  D_WIDTH  divisor for the group, 0 = none found.
REQ-015 ResultGrp  out  clog2(NUM_GROUPS)  group index of Result.
REQ-016 ResultValid / ResultAck  out / in  1  result handshake.
REQ-017 Busy  out  1  high from Go acceptance until Done.
REQ-018 Done  out  1  high from run end until next accepted Go.

Function
REQ-019 States SHALL be IDLE, GRP_INIT, RD_REQ, RD_WAIT, MOD_START, MOD_WAIT, EVAL, NEXT_CAND, EMIT, NEXT_GRP, FIN.
REQ-020 IDLE: Go=1 -> latch Mode/HitThresh, g=0, clear Done, -> GRP_INIT; Go while not IDLE ignored.
REQ-021 GRP_INIT: candidate V = 2 (Mode 0) or 2^D_WIDTH-1 (Mode 1), j=0, hits=0 -> RD_REQ.
REQ-022 RD_REQ: En=1 one cycle, Addr valid -> RD_WAIT; RD_WAIT captures Data -> MOD_START.
REQ-023 MOD_START/MOD_WAIT: compute Data mod V via sub-module in exactly D_WIDTH cycles; remainder 0 -> hits+1.
REQ-024 EVAL: j < GROUP_SIZE-1 -> j+1, RD_REQ; else hits >= threshold -> Result=V, EMIT; else NEXT_CAND.
REQ-025 NEXT_CAND: Mode 0 V+1, Mode 1 V-1, j=0, hits=0 -> RD_REQ; Mode 0 past 2^D_WIDTH-1 -> Result=0, EMIT; Mode 1 reaching V=1 always qualifies (Result=1).
REQ-026 Words are re-read for every candidate; no data caching.
REQ-027 EMIT: ResultValid=1, Result/ResultGrp stable until ResultAck=1 sampled; leave EMIT the cycle after ack.
REQ-028 ResultAck outside EMIT SHALL be ignored; ack in the first EMIT cycle accepted.
REQ-029 NEXT_GRP: g < NUM_GROUPS-1 -> g+1, GRP_INIT; else FIN.
REQ-030 FIN: Busy=0, Done=1 -> IDLE same edge.
REQ-031 Data word 0 SHALL count as divisible by every V.
REQ-032 Counters SHALL not wrap: candidate compare done at D_WIDTH+1 bits.

Reset
REQ-033 Rst=1 SHALL immediately force IDLE and Addr=0, En=0, Rw=0, Result=0, ResultGrp=0, ResultValid=0, Busy=0, Done=0, all counters 0, sub-module idle.
REQ-034 Reset mid-run SHALL abandon the run with no further En or ResultValid until a new Go.

Structure
REQ-035 Shared package SHALL hold state encoding constants and Mode encodings.
REQ-036 Sub-module mod_unit (restoring remainder, Start/Busy/Rem, D_WIDTH cycles) SHALL be instantiated once.

Verification (D_WIDTH=8, GROUP_SIZE=4, NUM_GROUPS=2)
REQ-037 Group0 {12,18,24,30}, Mode 0, HitThresh 4 -> Result 2, ResultGrp 0.
REQ-038 Same data, Mode 1 -> Result 6; group1 {7,11,13,17} Mode 1 -> Result 1.
REQ-039 Group {7,11,13,17}, Mode 0, HitThresh 4 -> Result 0; HitThresh 1 -> Result 7.
REQ-040 Group {0,0,0,0}: Mode 0 -> 2, Mode 1 -> 255; ResultAck delayed 5 cycles -> outputs held stable, no extra En.
REQ-041 Rst asserted during MOD_WAIT of group 1 -> all outputs reset values asynchronously; new Go restarts at Addr 0.
REQ-042 Go pulsed while Busy -> ignored; Done=1 only after second group acked.
